instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 118 +++++++++++
 tb/tb_instr_encoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Encodes register/immediate requests into 32-bit words and streams them to
// instruction memory through a small FIFO at consecutive word addresses.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_LOAD  | accepting requests, writing buffered words
//   S_DRAIN | input closed, flushing the FIFO
//   S_DONE  | one-cycle completion pulse
module instr_encoder #(
  parameter int ADDR_W     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   word_cnt,
  output logic              err_illegal,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count;
  logic              fifo_empty, fifo_full;
  logic              legal, accept, push, pop;
  logic [31:0]       enc;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign in_ready   = (state == S_LOAD) && !fifo_full;
  assign wr_valid   = !fifo_empty && ((state == S_LOAD) || (state == S_DRAIN));
  assign wr_data    = wr_valid ? mem[rd_ptr] : '0;
  assign done       = (state == S_DONE);
  assign accept     = in_valid && in_ready;
  assign push       = accept && legal;
  assign pop        = wr_valid && wr_ready;

  always_comb begin
    legal = 1'b1;
    enc   = '0;
    case (in_op)
      4'd0: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      4'd1: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      4'd2: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
      4'd3: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
      4'd4: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
      4'd5: enc = {6'b100011, in_rs, in_rt, in_imm};
      4'd6: enc = {6'b101011, in_rs, in_rt, in_imm};
      4'd7: enc = {6'b001000, in_rs, in_rt, in_imm};
      4'd8: enc = {6'b000100, in_rs, in_rt, in_imm};
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (finish) state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      wr_addr     <= '0;
      word_cnt    <= '0;
      err_illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
      if (state == S_IDLE && start) begin
        wr_addr     <= base_addr;
        word_cnt    <= '0;
        err_illegal <= 1'b0;
      end else begin
        if (pop) begin
          wr_addr <= wr_addr + ADDR_W'(1);
          if (word_cnt != CNT_MAX) word_cnt <= word_cnt + (ADDR_W+1)'(1);
        end
        if (accept && !legal) err_illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded words, addresses, counts,
// back-pressure, wrap, illegal ops, drain and reset during drain.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, start, finish, in_valid, in_ready, wr_valid, wr_ready;
  logic        err_illegal, done;
  logic [5:0]  base_addr, wr_addr;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [31:0] wr_data;
  logic [6:0]  word_cnt;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [31:0] wq_data [$];
  logic [5:0]  wq_addr [$];

  instr_encoder #(.ADDR_W(6), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .word_cnt(word_cnt),
    .err_illegal(err_illegal), .done(done)
  );

  always #5 clk = ~clk;

  // Inputs change only just after posedge, so the negedge view is what the next edge sees.
  always @(negedge clk) begin
    if (!reset && wr_valid && wr_ready) begin
      wq_data.push_back(wr_data);
      wq_addr.push_back(wr_addr);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [5:0] base);
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm);
    int n = 0;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_writes(input int total);
    int n = 0;
    while (wq_data.size() < total && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("write_timeout", wq_data.size(), total);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("done_timeout", done_cnt, target);
  endtask

  initial begin
    logic [31:0] exp_w [6];
    int base_q;

    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    base_addr = '0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    tick(3);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err_illegal, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_wr_data", wr_data, 0);
    reset = 1'b0;
    tick();

    // Session 1: encodings with wr_ready held high
    do_start(6'd5);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000);
    wait_writes(1);
    check("add_data", wq_data[0], 32'h00221820);
    check("add_addr", wq_addr[0], 6'd5);
    check("add_cnt", word_cnt, 7'd1);
    send(4'd5, 5'd29, 5'd8, 5'd7, 16'h0004);
    send(4'd8, 5'd1, 5'd2, 5'd9, 16'hFFFF);
    send(4'd4, 5'd1, 5'd2, 5'd3, 16'h0000);
    send(4'd6, 5'd2, 5'd3, 5'd0, 16'h0010);
    wait_writes(5);
    check("lw_data", wq_data[1], 32'h8FA80004);
    check("lw_addr", wq_addr[1], 6'd6);
    check("beq_data", wq_data[2], 32'h1022FFFF);
    check("beq_addr", wq_addr[2], 6'd7);
    check("slt_data", wq_data[3], 32'h0022182A);
    check("sw_data", wq_data[4], 32'hAC430010);
    check("s1_cnt", word_cnt, 7'd5);
    do_finish();
    wait_done(1);
    tick(2);
    check("s1_done_once", done_cnt, 1);

    // Session 2: back-pressure fills the FIFO
    wr_ready = 1'b0;
    base_q = wq_data.size();
    for (int i = 0; i < 6; i++) exp_w[i] = 32'h20000001 + i;
    do_start(6'd10);
    for (int i = 0; i < 4; i++) send(4'd7, 5'd0, 5'd0, 5'd0, 16'(i + 1));
    check("full_in_ready", in_ready, 0);
    check("full_wr_valid", wr_valid, 1);
    check("full_head", wr_data, 32'h20000001);
    check("full_addr", wr_addr, 6'd10);
    in_op = 4'd7; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = 16'd5; in_valid = 1'b1;
    tick(3);
    check("stall_in_ready", in_ready, 0);
    check("stall_head", wr_data, 32'h20000001);
    check("stall_addr", wr_addr, 6'd10);
    wr_ready = 1'b1;
    send(4'd7, 5'd0, 5'd0, 5'd0, 16'd5);
    send(4'd7, 5'd0, 5'd0, 5'd0, 16'd6);
    wait_writes(base_q + 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bp_data%0d", i), wq_data[base_q + i], exp_w[i]);
      check($sformatf("bp_addr%0d", i), wq_addr[base_q + i], 6'(10 + i));
    end
    do_finish();
    wait_done(2);

    // Session 3: address wrap and an illegal op
    base_q = wq_data.size();
    do_start(6'd63);
    send(4'd12, 5'd1, 5'd1, 5'd1, 16'h1234);
    check("illegal_err", err_illegal, 1);
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0000);
    send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0000);
    wait_writes(base_q + 2);
    tick(3);
    check("illegal_no_write", wq_data.size(), base_q + 2);
    check("wrap_data0", wq_data[base_q], 32'h00221822);
    check("wrap_addr0", wq_addr[base_q], 6'd63);
    check("wrap_data1", wq_data[base_q + 1], 32'h00221824);
    check("wrap_addr1", wq_addr[base_q + 1], 6'd0);
    check("wrap_cnt", word_cnt, 7'd2);
    do_finish();
    wait_done(3);
    tick();
    check("err_sticky", err_illegal, 1);

    // Session 4: word_cnt saturation
    do_start(6'd0);
    check("start_clears_err", err_illegal, 0);
    for (int i = 0; i < 65; i++) send(4'd7, 5'd0, 5'd0, 5'd0, 16'(i));
    tick(4);
    check("sat_cnt", word_cnt, 7'd64);
    check("sat_addr", wr_addr, 6'd1);
    do_finish();
    wait_done(4);

    // Session 5: drain three buffered words
    wr_ready = 1'b0;
    base_q = wq_data.size();
    do_start(6'd30);
    send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0000);
    send(4'd0, 5'd4, 5'd5, 5'd6, 16'h0000);
    send(4'd7, 5'd31, 5'd31, 5'd0, 16'h8000);
    do_finish();
    check("drain_in_ready", in_ready, 0);
    check("drain_wr_valid", wr_valid, 1);
    wr_ready = 1'b1;
    wait_done(5);
    check("drain_writes", wq_data.size(), base_q + 3);
    check("drain_d0", wq_data[base_q], 32'h00221825);
    check("drain_d1", wq_data[base_q + 1], 32'h00853020);
    check("drain_d2", wq_data[base_q + 2], 32'h23FF8000);
    check("drain_a2", wq_addr[base_q + 2], 6'd32);
    tick(3);
    check("done_one_cycle", done_cnt, 5);
    check("idle_in_ready", in_ready, 0);
    check("idle_wr_valid", wr_valid, 0);

    // Session 6: reset in the middle of DRAIN
    wr_ready = 1'b0;
    base_q = wq_data.size();
    do_start(6'd20);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000);
    do_finish();
    tick();
    reset = 1'b1;
    wr_ready = 1'b1;
    tick();
    check("rst_drain_valid", wr_valid, 0);
    check("rst_drain_data", wr_data, 0);
    check("rst_drain_cnt", word_cnt, 0);
    reset = 1'b0;
    tick(10);
    check("rst_drain_no_done", done_cnt, 5);
    check("rst_drain_no_write", wq_data.size(), base_q);
    check("rst_drain_idle", wr_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
